pwm_div_bank: RTL and testbench
===============================

Name: pwm_div_bank

Overview:
- Bank of N_CH independently programmable counter-based clock dividers / PWM generators for the audio codec interface.
- Generalises the fixed 10000-cycle, 50% square-wave divider: runtime period/threshold, four output modes, safe shadow-register reconfiguration, global enable and phase resync.
- Sits between the system clock and codec-side timing consumers (bit/frame strobes, LED/test waveforms).

Parameters:
- CNT_W, 16, counter/period/threshold width in bits.
- N_CH, 2, number of channels (>=1).
- DEF_PERIOD, 10000, period loaded at reset, in clk cycles.
- DEF_THRESH, 5000, threshold loaded at reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  global count enable; low freezes all channels.
- sync_all  in  1  one-cycle pulse; restarts all channels at count 0.
- cfg_wr  in  1  configuration write strobe.
- cfg_ch  in  CH_W  target channel, CH_W = max(1, clog2(N_CH)); values >= N_CH ignored (no ack).
- cfg_period  in  CNT_W  new period P.
- cfg_thresh  in  CNT_W  new threshold T.
- cfg_mode  in  2  0=PWM, 1=TOGGLE, 2=PULSE, 3=OFF.
- cfg_ack  out  1  one-cycle pulse the cycle after an accepted cfg_wr.
- out  out  N_CH  per-channel waveform, registered.
- wrap  out  N_CH  per-channel strobe, high in the last cycle of each period.

Behaviour:
- Reset: all counts 0, active P=DEF_PERIOD, T=DEF_THRESH, mode PWM; pending slots empty; out=0, wrap=0, cfg_ack=0.
- Effective period Peff = max(P, 2); values 0/1 clamp to 2.
- Counting: when enable=1 and mode!=OFF, count increments each cycle; count==Peff-1 -> 0 next cycle. enable=0 holds count and out; wrap forced 0.
- wrap[i]=1 exactly in cycles where enable=1, mode!=OFF and count==Peff-1.
- out[i] registered, value at cycle t is f(count at t), glitch-free:
  PWM: 1 iff count >= T (T=0 -> constant 1; T >= Peff -> constant 0).
  TOGGLE: inverts at each wrap (output period 2*Peff); T unused.
  PULSE: 1 iff count == T (never, if T >= Peff).
  OFF: out=0, count held at 0, wrap=0.
- Reconfiguration: accepted cfg_wr stores {P,T,mode} in channel's pending slot; later write before apply overwrites (last wins).
- Pending applied at next wrap edge (count -> 0 with new values); applied immediately next cycle if channel is currently OFF.
- cfg_wr in the same cycle as that channel's wrap is applied at that wrap (bypass).
- Switching into TOGGLE clears out to 0 on apply.
- sync_all: next cycle all counts=0, all pending slots applied, TOGGLE outs cleared; works even with enable=0.
- Priority: reset > sync_all > cfg apply > enable/count.
- Reset mid-operation: discards pending writes, restores defaults, no cfg_ack.
- Arithmetic unsigned, CNT_W bits; no overflow since count < Peff <= 2^CNT_W-1.

Decomposition:
- Shared package pwm_div_pkg: mode constants (MODE_PWM, MODE_TOGGLE, MODE_PULSE, MODE_OFF), mode width 2, CH_W helper function.
- Sub-module pwm_div_channel: one counter, active and pending config registers, output logic.
- Top: cfg decode, cfg_ack, generate loop over N_CH.

Test Plan:
- Defaults after reset, enable=1: out 0 for 5000 cycles, 1 for 5000; wrap high every 10000th cycle; both channels identical.
- Mid-period write ch0 P=4,T=1,PWM at count 100: no change until wrap at count 9999, then out 0,1,1,1 repeating; cfg_ack one cycle after write; ch1 unaffected.
- TOGGLE P=3: out toggles every 3 cycles (0,0,0,1,1,1,...); PULSE P=4,T=0: out 1,0,0,0 repeating; wrap aligned to count 3.
- enable low 7 cycles holds count/out, wrap=0; sync_all with ch0 P=4 and ch1 P=6 at arbitrary phases: both counts 0 next cycle, wraps coincide every 12 cycles.
- Boundaries: P=0 -> behaves as P=2; PWM T=5 with P=4 -> out constant 0; T=0 -> constant 1; cfg_ch=N_CH -> ignored, no ack; write coincident with wrap applies that wrap.
- Reset asserted with a pending write: defaults restored, pending discarded, out=0, cfg_ack=0 next cycle.

Source files
------------

// File: rtl/pwm_div_pkg.sv
// Shared definitions for the pwm_div_bank codec timing block.
// Provides the channel mode encoding and the helper that sizes the
// channel-select field of the configuration port.
package pwm_div_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_PWM    = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_PULSE  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_t;

    // Channel-select width: at least one bit even for a single channel.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_div_channel.sv
// One programmable divider / PWM channel.
// Holds an active configuration that drives the counter and a pending
// (shadow) slot that is committed only at a period boundary, so the
// waveform never glitches mid-period.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   enable          count enable; low freezes count and out, forces wrap 0
//   sync_all        restart at count 0 and commit pending configuration
//   wr              configuration write aimed at this channel
//   period, thresh  new period / threshold for the pending slot
//   mode            new output mode for the pending slot
//   out             registered waveform, a function of the current count
//   wrap            high in the last cycle of each period
module pwm_div_channel
    import pwm_div_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 10000,
    parameter int DEF_THRESH = 5000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_all,
    input  logic             wr,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] thresh,
    input  mode_t            mode,
    output logic             out,
    output logic             wrap
);

    logic [CNT_W-1:0] count, act_period, act_thresh, pend_period, pend_thresh;
    mode_t            act_mode, pend_mode;
    logic             pend_valid, tog;

    logic [CNT_W-1:0] peff;
    logic             last;

    // Periods of 0 or 1 cannot produce a two-phase waveform; clamp to 2.
    assign peff = (act_period < CNT_W'(2)) ? CNT_W'(2) : act_period;
    assign last = (count == peff - CNT_W'(1));
    assign wrap = enable && (act_mode != MODE_OFF) && last;

    logic [CNT_W-1:0] n_count, n_period, n_thresh, n_pend_period, n_pend_thresh;
    mode_t            n_mode, n_pend_mode;
    logic             n_pend_valid, n_tog, n_out, apply;

    always_comb begin
        // A write in this cycle lands in the slot first, so a write that
        // coincides with the wrap is committed at that same wrap.
        n_pend_valid  = pend_valid;
        n_pend_period = pend_period;
        n_pend_thresh = pend_thresh;
        n_pend_mode   = pend_mode;
        if (wr) begin
            n_pend_valid  = 1'b1;
            n_pend_period = period;
            n_pend_thresh = thresh;
            n_pend_mode   = mode;
        end

        apply = sync_all || (n_pend_valid && (wrap || act_mode == MODE_OFF));

        n_period = act_period;
        n_thresh = act_thresh;
        n_mode   = act_mode;

        if (sync_all) begin
            n_tog = 1'b0;
        end else if (wrap) begin
            n_tog = ~tog;
        end else begin
            n_tog = tog;
        end

        if (apply && n_pend_valid) begin
            n_period     = n_pend_period;
            n_thresh     = n_pend_thresh;
            n_mode       = n_pend_mode;
            n_pend_valid = 1'b0;
            // Entering TOGGLE always starts from a low phase.
            if (n_pend_mode == MODE_TOGGLE && act_mode != MODE_TOGGLE) begin
                n_tog = 1'b0;
            end
        end

        if (apply || n_mode == MODE_OFF) begin
            n_count = '0;
        end else if (!enable) begin
            n_count = count;
        end else if (last) begin
            n_count = '0;
        end else begin
            n_count = count + CNT_W'(1);
        end

        // out is registered from the next count so that its value in any
        // cycle corresponds to the count held in that same cycle.
        case (n_mode)
            MODE_PWM:    n_out = (n_count >= n_thresh);
            MODE_TOGGLE: n_out = n_tog;
            MODE_PULSE:  n_out = (n_count == n_thresh);
            default:     n_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            act_period  <= CNT_W'(DEF_PERIOD);
            act_thresh  <= CNT_W'(DEF_THRESH);
            act_mode    <= MODE_PWM;
            pend_valid  <= 1'b0;
            pend_period <= '0;
            pend_thresh <= '0;
            pend_mode   <= MODE_PWM;
            tog         <= 1'b0;
            out         <= 1'b0;
        end else begin
            count       <= n_count;
            act_period  <= n_period;
            act_thresh  <= n_thresh;
            act_mode    <= n_mode;
            pend_valid  <= n_pend_valid;
            pend_period <= n_pend_period;
            pend_thresh <= n_pend_thresh;
            pend_mode   <= n_pend_mode;
            tog         <= n_tog;
            out         <= n_out;
        end
    end

endmodule

// File: rtl/pwm_div_bank.sv
// Bank of N_CH independent divider / PWM channels for the codec interface.
// Decodes the shared configuration port, acknowledges accepted writes and
// instantiates one pwm_div_channel per output.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable            global count enable
//   sync_all          one-cycle pulse restarting every channel at count 0
//   cfg_wr, cfg_ch    write strobe and target channel (out-of-range ignored)
//   cfg_period/thresh/mode   configuration written to the pending slot
//   cfg_ack           one-cycle pulse the cycle after an accepted write
//   out, wrap         per-channel waveform and end-of-period strobe
module pwm_div_bank
    import pwm_div_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int N_CH       = 2,
    parameter int DEF_PERIOD = 10000,
    parameter int DEF_THRESH = 5000,
    localparam int CH_W      = ch_width(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync_all,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic [MODE_W-1:0] cfg_mode,
    output logic              cfg_ack,
    output logic [N_CH-1:0]   out,
    output logic [N_CH-1:0]   wrap
);

    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    logic accept;
    assign accept = cfg_wr && ({1'b0, cfg_ch} < N_CH_L);

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= accept;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pwm_div_channel #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_THRESH (DEF_THRESH)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .sync_all (sync_all),
            .wr       (accept && (cfg_ch == CH_W'(g))),
            .period   (cfg_period),
            .thresh   (cfg_thresh),
            .mode     (mode_t'(cfg_mode)),
            .out      (out[g]),
            .wrap     (wrap[g])
        );
    end

endmodule

// File: tb/tb_pwm_div_bank.sv
module tb_pwm_div_bank;

    localparam int CNT_W = 16;
    localparam int N_CH  = 3;
    localparam int CH_W  = 2;
    localparam int DEF_P = 10000;
    localparam int DEF_T = 5000;

    logic             clk = 1'b0;
    logic             reset, enable, sync_all, cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_period, cfg_thresh;
    logic [1:0]       cfg_mode;
    logic             cfg_ack;
    logic [N_CH-1:0]  out, wrap;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_div_bank #(
        .CNT_W(CNT_W), .N_CH(N_CH), .DEF_PERIOD(DEF_P), .DEF_THRESH(DEF_T)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sync_all(sync_all),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .cfg_thresh(cfg_thresh), .cfg_mode(cfg_mode), .cfg_ack(cfg_ack),
        .out(out), .wrap(wrap)
    );

    // Behavioural reference: per-channel count, active/pending config,
    // and the number of toggle-mode wraps seen since the waveform restarted.
    int m_cnt[N_CH], m_p[N_CH], m_t[N_CH], m_mode[N_CH];
    int m_pv[N_CH], m_pp[N_CH], m_pt[N_CH], m_pm[N_CH], m_tog[N_CH];
    bit m_ack;

    function automatic int model_peff(int c);
        return (m_p[c] < 2) ? 2 : m_p[c];
    endfunction

    function automatic bit model_wrap(int c);
        return enable && (m_mode[c] != 3) && (m_cnt[c] == model_peff(c) - 1);
    endfunction

    function automatic bit model_out(int c);
        case (m_mode[c])
            0:       return m_cnt[c] >= m_t[c];
            1:       return m_tog[c][0];
            2:       return m_cnt[c] == m_t[c];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [N_CH-1:0] exp_out();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = model_out(c);
        return v;
    endfunction

    function automatic logic [N_CH-1:0] exp_wrap();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = model_wrap(c);
        return v;
    endfunction

    task automatic model_step();
        bit w, apply;
        int old_mode;
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                m_cnt[c] = 0; m_p[c] = DEF_P; m_t[c] = DEF_T; m_mode[c] = 0;
                m_pv[c] = 0; m_tog[c] = 0;
            end
            m_ack = 1'b0;
            return;
        end
        m_ack = cfg_wr && (int'(cfg_ch) < N_CH);
        for (int c = 0; c < N_CH; c++) begin
            w = model_wrap(c);
            old_mode = m_mode[c];
            if (cfg_wr && int'(cfg_ch) == c) begin
                m_pp[c] = int'(cfg_period); m_pt[c] = int'(cfg_thresh);
                m_pm[c] = int'(cfg_mode); m_pv[c] = 1;
            end
            apply = sync_all || (m_pv[c] != 0 && (w || old_mode == 3));
            if (w && old_mode == 1) m_tog[c] = m_tog[c] + 1;
            if (sync_all) m_tog[c] = 0;
            if (apply && m_pv[c] != 0) begin
                m_p[c] = m_pp[c]; m_t[c] = m_pt[c]; m_mode[c] = m_pm[c]; m_pv[c] = 0;
                if (m_mode[c] == 1 && old_mode != 1) m_tog[c] = 0;
            end
            if (apply || m_mode[c] == 3) m_cnt[c] = 0;
            else if (enable) m_cnt[c] = (m_cnt[c] == model_peff(c) - 1) ? 0 : m_cnt[c] + 1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int p, input int t, input int m);
        cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_period = CNT_W'(p);
        cfg_thresh = CNT_W'(t); cfg_mode = 2'(m);
        cycle();
        cfg_wr = 1'b0;
    endtask

    task automatic sync_pulse();
        sync_all = 1'b1;
        cycle();
        sync_all = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; sync_all = 1'b0; cfg_wr = 1'b0;
        cfg_ch = '0; cfg_period = '0; cfg_thresh = '0; cfg_mode = '0;
        repeat (3) cycle();
        reset = 1'b0;
        checks++;
        if (out !== 3'b000) begin errors++; $display("FAIL reset_out: got %b want 000", out); end
        checks++;
        if (wrap !== 3'b000) begin errors++; $display("FAIL reset_wrap: got %b want 000", wrap); end
        checks++;
        if (cfg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", cfg_ack); end
    endtask

    task automatic test_defaults();
        int ones = 0, wraps = 0, first_high = -1, diff = 0, bad = 0;
        enable = 1'b1;
        for (int i = 0; i < DEF_P; i++) begin
            if (out[0] === 1'b1) begin ones++; if (first_high < 0) first_high = i; end
            if (wrap[0] === 1'b1) wraps++;
            if (out[1] !== out[0] || out[2] !== out[0]) diff++;
            if (out !== exp_out() || wrap !== exp_wrap()) bad++;
            cycle();
        end
        checks++;
        if (ones != 5000) begin errors++; $display("FAIL dflt_high_cycles: got %0d want 5000", ones); end
        checks++;
        if (first_high != 5000) begin errors++; $display("FAIL dflt_first_high: got %0d want 5000", first_high); end
        checks++;
        if (wraps != 1) begin errors++; $display("FAIL dflt_wrap_count: got %0d want 1", wraps); end
        checks++;
        if (diff != 0) begin errors++; $display("FAIL dflt_channels_equal: got %0d differing cycles want 0", diff); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL dflt_model: got %0d mismatching cycles want 0", bad); end
    endtask

    task automatic test_mid_write();
        int bad = 0;
        bit seen = 1'b0;
        repeat (100) cycle();
        cfg_write(0, 4, 1, 0);
        checks++;
        if (cfg_ack !== 1'b1) begin errors++; $display("FAIL mid_ack: got %b want 1", cfg_ack); end
        cycle();
        checks++;
        if (cfg_ack !== 1'b0) begin errors++; $display("FAIL mid_ack_pulse: got %b want 0", cfg_ack); end
        for (int i = 0; i < DEF_P && !seen; i++) begin
            if (out !== exp_out() || wrap !== exp_wrap()) bad++;
            if (wrap[0] === 1'b1) seen = 1'b1;
            cycle();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_wrap_timeout: got no wrap want wrap"); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_pre_wrap: got %0d mismatching cycles want 0", bad); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out[0] !== (k % 4 != 0)) begin
                errors++; $display("FAIL mid_pwm_pattern k=%0d: got %b want %b", k, out[0], k % 4 != 0);
            end
            checks++;
            if (out[2:1] !== exp_out() >> 1) begin
                errors++; $display("FAIL mid_other_ch k=%0d: got %b want %b", k, out[2:1], exp_out() >> 1);
            end
            cycle();
        end
    endtask

    task automatic test_toggle_pulse();
        cfg_write(0, 3, 0, 1);
        cfg_write(1, 4, 0, 2);
        sync_pulse();
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (out[0] !== ((k / 3) % 2 == 1)) begin
                errors++; $display("FAIL toggle k=%0d: got %b want %b", k, out[0], (k / 3) % 2 == 1);
            end
            checks++;
            if (out[1] !== (k % 4 == 0) || wrap[1] !== (k % 4 == 3)) begin
                errors++; $display("FAIL pulse k=%0d: got out=%b wrap=%b want out=%b wrap=%b",
                                   k, out[1], wrap[1], k % 4 == 0, k % 4 == 3);
            end
            cycle();
        end
    endtask

    task automatic test_enable_sync();
        logic [N_CH-1:0] held;
        cfg_write(0, 4, 2, 0);
        cfg_write(1, 6, 3, 0);
        repeat (10 + $urandom_range(0, 9)) cycle();
        held = out;
        enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            checks++;
            if (wrap !== 3'b000 || out !== held) begin
                errors++; $display("FAIL enable_hold k=%0d: got out=%b wrap=%b want out=%b wrap=000", k, out, wrap, held);
            end
        end
        enable = 1'b1;
        sync_pulse();
        for (int k = 0; k < 24; k++) begin
            checks++;
            if ((wrap[0] & wrap[1]) !== (k % 12 == 11) || out !== exp_out()) begin
                errors++; $display("FAIL sync_align k=%0d: got wrap=%b out=%b want both=%b out=%b",
                                   k, wrap, out, k % 12 == 11, exp_out());
            end
            cycle();
        end
    endtask

    task automatic test_boundaries();
        int guard = 0;
        cfg_write(0, 0, 1, 0);
        sync_pulse();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (out[0] !== (k % 2 == 1) || wrap[0] !== (k % 2 == 1)) begin
                errors++; $display("FAIL p0_clamp k=%0d: got out=%b wrap=%b want %b", k, out[0], wrap[0], k % 2 == 1);
            end
            cycle();
        end
        cfg_write(0, 4, 5, 0);
        sync_pulse();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out[0] !== 1'b0) begin errors++; $display("FAIL thresh_over k=%0d: got %b want 0", k, out[0]); end
            cycle();
        end
        cfg_write(0, 4, 0, 0);
        sync_pulse();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out[0] !== 1'b1) begin errors++; $display("FAIL thresh_zero k=%0d: got %b want 1", k, out[0]); end
            cycle();
        end
        cfg_write(3, 2, 1, 3);
        checks++;
        if (cfg_ack !== 1'b0) begin errors++; $display("FAIL bad_ch_ack: got %b want 0", cfg_ack); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out !== exp_out() || wrap !== exp_wrap()) begin
                errors++; $display("FAIL bad_ch_ignored k=%0d: got %b/%b want %b/%b", k, out, wrap, exp_out(), exp_wrap());
            end
            cycle();
        end
        while (!model_wrap(0) && guard < 10) begin cycle(); guard++; end
        checks++;
        if (guard >= 10) begin errors++; $display("FAIL coincide_timeout: got no wrap want wrap"); end
        cfg_write(0, 5, 2, 0);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (out[0] !== (k % 5 >= 2)) begin
                errors++; $display("FAIL coincide_apply k=%0d: got %b want %b", k, out[0], k % 5 >= 2);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(0, 9) != 0);
            sync_all = ($urandom_range(0, 49) == 0);
            cfg_wr   = ($urandom_range(0, 9) == 0);
            cfg_ch   = CH_W'($urandom_range(0, 3));
            cfg_period = CNT_W'($urandom_range(0, 12));
            cfg_thresh = CNT_W'($urandom_range(0, 13));
            cfg_mode   = 2'($urandom_range(0, 3));
            cycle();
            checks++;
            if (out !== exp_out() || wrap !== exp_wrap() || cfg_ack !== m_ack) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL random i=%0d: got out=%b wrap=%b ack=%b want out=%b wrap=%b ack=%b",
                                       i, out, wrap, cfg_ack, exp_out(), exp_wrap(), m_ack);
            end
        end
        enable = 1'b1; sync_all = 1'b0; cfg_wr = 1'b0;
    endtask

    task automatic test_reset_pending();
        int bad = 0;
        cfg_write(1, 7, 0, 1);
        cfg_write(0, 3, 1, 2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (out !== 3'b000 || cfg_ack !== 1'b0) begin
            errors++; $display("FAIL reset_pending: got out=%b ack=%b want out=000 ack=0", out, cfg_ack);
        end
        for (int i = 0; i < DEF_P + 10; i++) begin
            if (out !== exp_out() || wrap !== exp_wrap() || cfg_ack !== 1'b0) bad++;
            cycle();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_defaults: got %0d mismatching cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_mid_write();
        test_toggle_pulse();
        test_enable_sync();
        test_boundaries();
        test_random();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
